// File: rtl/mshr_ctrl.sv
// MEM-stage memory controller: hit/miss/stall classification, in-order MSHR, 1-entry store buffer.
// Optional event counters are built when MSHR_PERF_EN is defined.
module mshr_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_req,
    input  logic        mmio_lw,
    input  logic [31:0] mmio_addr,
    input  logic [31:0] mmio_data_write,
    input  logic [4:0]  mmio_regD,
    output logic [31:0] mmio_data_read,
    output logic        hit_ack,
    output logic        miss_store,
    output logic        passive_stall,
    output logic        load_done_stall,
    output logic [4:0]  regD_done,
    output logic [31:0] cl_addr,
    input  logic        cl_hit,
    input  logic [31:0] cl_data,
    output logic        cf_valid,
    output logic [31:0] cf_addr,
    output logic [31:0] cf_data,
    output logic        mem_req_valid,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss,
    output logic [31:0] perf_stall
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} r_state_e;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    logic [31:0]      ent_addr_q [DEPTH];
    logic [31:0]      ent_addr_d [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [31:0]      ent_data_d [DEPTH];
    logic [4:0]       ent_rd_q   [DEPTH];
    logic [4:0]       ent_rd_d   [DEPTH];
    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [DEPTH-1:0] ent_iss_q, ent_iss_d;
    logic [DEPTH-1:0] ent_done_q, ent_done_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, iss_ptr_q, iss_ptr_d, r_idx_q, r_idx_d;
    logic [CW-1:0]    count_q, count_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_addr_q, wb_addr_d, wb_data_q, wb_data_d;

    r_state_e    r_state_q, r_state_d;

    logic        hit_ack_q, hit_ack_d, miss_store_q, miss_store_d;
    logic        passive_stall_q, passive_stall_d, load_done_stall_q, load_done_stall_d;
    logic [31:0] data_read_q, data_read_d;
    logic [4:0]  regd_done_q, regd_done_d;
    logic        cf_valid_q, cf_valid_d;
    logic [31:0] cf_addr_q, cf_addr_d, cf_data_q, cf_data_d;

    logic complete_now, req_live, mshr_full, mshr_empty;
    logic load_hit, do_push, load_stall, store_ok, store_stall;
    logic rd_cand, rd_accept, rd_capture;

    // A completing head entry owns the response slot; a request arriving the same cycle is dropped.
    always_comb begin
        complete_now = ent_vld_q[head_q] && ent_done_q[head_q];
        req_live     = mmio_req && !complete_now;
        mshr_full    = (count_q == FULL_CNT);
        mshr_empty   = (count_q == '0);
        load_hit     = req_live && mmio_lw && cl_hit;
        do_push      = req_live && mmio_lw && !cl_hit && !mshr_full;
        load_stall   = req_live && mmio_lw && !cl_hit && mshr_full;
        store_ok     = req_live && !mmio_lw && mshr_empty && !wb_valid_q;
        store_stall  = req_live && !mmio_lw && !(mshr_empty && !wb_valid_q);
        rd_cand      = ent_vld_q[iss_ptr_q] && !ent_iss_q[iss_ptr_q] && !wb_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d  = r_state_q;
        rd_accept  = 1'b0;
        rd_capture = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (rd_cand) begin
                    if (mem_req_ready) begin
                        rd_accept = 1'b1;
                        r_state_d = R_WAIT;
                    end else begin
                        r_state_d = R_REQ;
                    end
                end
            end
            R_REQ: begin
                if (mem_req_ready && !wb_valid_q) begin
                    rd_accept = 1'b1;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (mem_rsp_valid) begin
                    rd_capture = 1'b1;
                    r_state_d  = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // The write buffer always wins the memory port; reads present the oldest un-issued entry.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        if (wb_valid_q) begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = wb_addr_q;
            mem_req_wdata = wb_data_q;
        end else if ((r_state_q == R_IDLE && rd_cand) || r_state_q == R_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = ent_addr_q[iss_ptr_q];
        end
    end

    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_rd_d   = ent_rd_q;
        ent_vld_d  = ent_vld_q;
        ent_iss_d  = ent_iss_q;
        ent_done_d = ent_done_q;
        head_d     = head_q;
        tail_d     = tail_q;
        iss_ptr_d  = iss_ptr_q;
        r_idx_d    = r_idx_q;
        count_d    = count_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;

        if (rd_accept) begin
            ent_iss_d[iss_ptr_q] = 1'b1;
            r_idx_d              = iss_ptr_q;
            iss_ptr_d            = ptr_inc(iss_ptr_q);
        end
        if (rd_capture) begin
            ent_data_d[r_idx_q] = mem_rsp_data;
            ent_done_d[r_idx_q] = 1'b1;
        end
        if (complete_now) begin
            ent_vld_d[head_q]  = 1'b0;
            ent_done_d[head_q] = 1'b0;
            head_d             = ptr_inc(head_q);
        end
        if (do_push) begin
            ent_addr_d[tail_q] = mmio_addr;
            ent_rd_d[tail_q]   = mmio_regD;
            ent_vld_d[tail_q]  = 1'b1;
            ent_iss_d[tail_q]  = 1'b0;
            ent_done_d[tail_q] = 1'b0;
            tail_d             = ptr_inc(tail_q);
        end
        case ({do_push, complete_now})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (store_ok) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = mmio_addr;
            wb_data_d  = mmio_data_write;
        end else if (wb_valid_q && mem_req_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    always_comb begin
        hit_ack_d         = load_hit || store_ok;
        miss_store_d      = do_push;
        passive_stall_d   = load_stall || store_stall;
        load_done_stall_d = complete_now;
        data_read_d       = '0;
        regd_done_d       = '0;
        cf_valid_d        = 1'b0;
        cf_addr_d         = '0;
        cf_data_d         = '0;
        if (complete_now) begin
            data_read_d = ent_data_q[head_q];
            regd_done_d = ent_rd_q[head_q];
            cf_valid_d  = 1'b1;
            cf_addr_d   = ent_addr_q[head_q];
            cf_data_d   = ent_data_q[head_q];
        end else if (load_hit) begin
            data_read_d = cl_data;
        end else if (store_ok && cl_hit) begin
            cf_valid_d = 1'b1;
            cf_addr_d  = mmio_addr;
            cf_data_d  = mmio_data_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
                ent_rd_q[i]   <= '0;
            end
            ent_vld_q         <= '0;
            ent_iss_q         <= '0;
            ent_done_q        <= '0;
            head_q            <= '0;
            tail_q            <= '0;
            iss_ptr_q         <= '0;
            r_idx_q           <= '0;
            count_q           <= '0;
            wb_valid_q        <= 1'b0;
            wb_addr_q         <= '0;
            wb_data_q         <= '0;
            hit_ack_q         <= 1'b0;
            miss_store_q      <= 1'b0;
            passive_stall_q   <= 1'b0;
            load_done_stall_q <= 1'b0;
            data_read_q       <= '0;
            regd_done_q       <= '0;
            cf_valid_q        <= 1'b0;
            cf_addr_q         <= '0;
            cf_data_q         <= '0;
        end else begin
            ent_addr_q        <= ent_addr_d;
            ent_data_q        <= ent_data_d;
            ent_rd_q          <= ent_rd_d;
            ent_vld_q         <= ent_vld_d;
            ent_iss_q         <= ent_iss_d;
            ent_done_q        <= ent_done_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            iss_ptr_q         <= iss_ptr_d;
            r_idx_q           <= r_idx_d;
            count_q           <= count_d;
            wb_valid_q        <= wb_valid_d;
            wb_addr_q         <= wb_addr_d;
            wb_data_q         <= wb_data_d;
            hit_ack_q         <= hit_ack_d;
            miss_store_q      <= miss_store_d;
            passive_stall_q   <= passive_stall_d;
            load_done_stall_q <= load_done_stall_d;
            data_read_q       <= data_read_d;
            regd_done_q       <= regd_done_d;
            cf_valid_q        <= cf_valid_d;
            cf_addr_q         <= cf_addr_d;
            cf_data_q         <= cf_data_d;
        end
    end

    assign cl_addr         = mmio_addr;
    assign hit_ack         = hit_ack_q;
    assign miss_store      = miss_store_q;
    assign passive_stall   = passive_stall_q;
    assign load_done_stall = load_done_stall_q;
    assign mmio_data_read  = data_read_q;
    assign regD_done       = regd_done_q;
    assign cf_valid        = cf_valid_q;
    assign cf_addr         = cf_addr_q;
    assign cf_data         = cf_data_q;

`ifdef MSHR_PERF_EN
    logic [31:0] perf_hit_q, perf_hit_d, perf_miss_q, perf_miss_d, perf_stall_q, perf_stall_d;

    // Counters saturate rather than wrap so long runs never read back as small values.
    always_comb begin
        perf_hit_d   = perf_hit_q;
        perf_miss_d  = perf_miss_q;
        perf_stall_d = perf_stall_q;
        if (hit_ack_d && perf_hit_q != 32'hFFFF_FFFF) perf_hit_d = perf_hit_q + 1'b1;
        if (miss_store_d && perf_miss_q != 32'hFFFF_FFFF) perf_miss_d = perf_miss_q + 1'b1;
        if (passive_stall_d && perf_stall_q != 32'hFFFF_FFFF) perf_stall_d = perf_stall_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit_q   <= '0;
            perf_miss_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_hit_q   <= perf_hit_d;
            perf_miss_q  <= perf_miss_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_hit   = perf_hit_q;
    assign perf_miss  = perf_miss_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_hit   = '0;
    assign perf_miss  = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_mshr_ctrl.sv
// Testbench for mshr_ctrl: vector table for single-cycle hits/stores plus directed miss, ordering,
// write-buffer, collision and reset sequences, all checked through an expected-response queue.
module tb_mshr_ctrl;

    localparam int K_HIT   = 0;
    localparam int K_MISS  = 1;
    localparam int K_STALL = 2;
    localparam int K_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mmio_req, mmio_lw;
    logic [31:0] mmio_addr, mmio_data_write;
    logic [4:0]  mmio_regD;
    logic [31:0] mmio_data_read;
    logic        hit_ack, miss_store, passive_stall, load_done_stall;
    logic [4:0]  regD_done;
    logic [31:0] cl_addr;
    logic        cl_hit;
    logic [31:0] cl_data;
    logic        cf_valid;
    logic [31:0] cf_addr, cf_data;
    logic        mem_req_valid, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_req_ready, mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [31:0] perf_hit, perf_miss, perf_stall;

    mshr_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mmio_req(mmio_req), .mmio_lw(mmio_lw), .mmio_addr(mmio_addr),
        .mmio_data_write(mmio_data_write), .mmio_regD(mmio_regD),
        .mmio_data_read(mmio_data_read), .hit_ack(hit_ack), .miss_store(miss_store),
        .passive_stall(passive_stall), .load_done_stall(load_done_stall), .regD_done(regD_done),
        .cl_addr(cl_addr), .cl_hit(cl_hit), .cl_data(cl_data),
        .cf_valid(cf_valid), .cf_addr(cf_addr), .cf_data(cf_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .perf_hit(perf_hit), .perf_miss(perf_miss), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        bit          chk_data;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        cfv;
        logic [31:0] cfa;
        logic [31:0] cfd;
    } exp_t;

    typedef struct {
        logic        lw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic [31:0] cdata;
        logic [31:0] exp_data;
        logic        exp_cfv;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_hit_cnt = 0, exp_miss_cnt = 0, exp_stall_cnt = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int kind, input bit chk_data, input logic [31:0] data,
                            input logic [4:0] rd, input logic cfv, input logic [31:0] cfa,
                            input logic [31:0] cfd);
        exp_t e;
        e.kind = kind; e.chk_data = chk_data; e.data = data; e.rd = rd;
        e.cfv = cfv; e.cfa = cfa; e.cfd = cfd;
        sb_q.push_back(e);
        if (kind == K_HIT) exp_hit_cnt++;
        if (kind == K_MISS) exp_miss_cnt++;
        if (kind == K_STALL) exp_stall_cnt++;
    endtask

    // Every response pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (hit_ack || miss_store || passive_stall || load_done_stall)) begin
            int   nhigh;
            int   act_kind;
            exp_t e;
            nhigh = int'(hit_ack) + int'(miss_store) + int'(passive_stall) + int'(load_done_stall);
            act_kind = hit_ack ? K_HIT : miss_store ? K_MISS : passive_stall ? K_STALL : K_DONE;
            check_output("resp_onehot", nhigh, 1);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_resp: got kind %0d expected no response", act_kind);
            end else begin
                e = sb_q.pop_front();
                check_output("resp_kind", act_kind, e.kind);
                if (e.chk_data) check_output("resp_data", mmio_data_read, e.data);
                if (e.kind == K_DONE) check_output("regD_done", {27'd0, regD_done}, {27'd0, e.rd});
                check_output("cf_valid", {31'd0, cf_valid}, {31'd0, e.cfv});
                if (e.cfv) begin
                    check_output("cf_addr", cf_addr, e.cfa);
                    check_output("cf_data", cf_data, e.cfd);
                end
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic lw, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [4:0] rd, input logic hit, input logic [31:0] cdata);
        mmio_req = 1'b1; mmio_lw = lw; mmio_addr = addr; mmio_data_write = wdata;
        mmio_regD = rd; cl_hit = hit; cl_data = cdata;
        #1;
        check_output("cl_addr", cl_addr, addr);
        @(posedge clk);
        #1;
        mmio_req = 1'b0; cl_hit = 1'b0;
    endtask

    task automatic drive_rsp(input logic [31:0] data);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) idle();
        idle();
        check_output("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{1'b1, 32'h0000_0100, 32'h0,    1'b1, 32'h0000_0055, 32'h0000_0055, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0104, 32'h0,    1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0108, 32'h1234, 1'b1, 32'h0,         32'h0,         1'b1};
        vecs[3] = '{1'b0, 32'h0000_010C, 32'h0009, 1'b0, 32'h0,         32'h0,         1'b0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0,    1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'h0,    1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};

        rst = 1'b1; mmio_req = 1'b0; mmio_lw = 1'b0; mmio_addr = '0; mmio_data_write = '0;
        mmio_regD = '0; cl_hit = 1'b0; cl_data = '0; mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_hit_ack", {31'd0, hit_ack}, 32'd0);
        check_output("rst_ld_done", {31'd0, load_done_stall}, 32'd0);
        check_output("rst_mem_req", {31'd0, mem_req_valid}, 32'd0);
        check_output("rst_cf_valid", {31'd0, cf_valid}, 32'd0);
        check_output("rst_perf_hit", perf_hit, 32'd0);
        rst = 1'b0;
        idle();

        $display("[TB] vector table: hits and stores with empty MSHR");
        for (int i = 0; i < 6; i++) begin
            push_exp(K_HIT, vecs[i].lw, vecs[i].exp_data, 5'd0, vecs[i].exp_cfv,
                     vecs[i].addr, vecs[i].wdata);
            apply_stimulus(vecs[i].lw, vecs[i].addr, vecs[i].wdata, 5'd0, vecs[i].hit, vecs[i].cdata);
            check_output("hit_latency", {31'd0, hit_ack}, 32'd1);
            if (vecs[i].lw) begin
                check_output("hit_no_mem", {31'd0, mem_req_valid}, 32'd0);
            end else begin
                check_output("wb_we", {31'd0, mem_req_we}, 32'd1);
                check_output("wb_addr", mem_req_addr, vecs[i].addr);
                check_output("wb_wdata", mem_req_wdata, vecs[i].wdata);
            end
            idle();
        end
        wait_drain(10);

        $display("[TB] single miss");
        push_exp(K_MISS, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b1, 32'h200, 32'd0, 5'd7, 1'b0, 32'd0);
        check_output("miss_rd_valid", {31'd0, mem_req_valid}, 32'd1);
        check_output("miss_rd_we", {31'd0, mem_req_we}, 32'd0);
        check_output("miss_rd_addr", mem_req_addr, 32'h200);
        idle();
        check_output("one_outstanding", {31'd0, mem_req_valid}, 32'd0);
        push_exp(K_DONE, 1'b1, 32'hABCD, 5'd7, 1'b1, 32'h200, 32'hABCD);
        drive_rsp(32'hABCD);
        wait_drain(10);

        $display("[TB] fill MSHR then drain in order");
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_exp(K_MISS, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
            else       push_exp(K_STALL, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
            apply_stimulus(1'b1, 32'h400 + 32'(4 * i), 32'd0, 5'(i + 1), 1'b0, 32'd0);
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            push_exp(K_DONE, 1'b1, 32'hD000 + 32'(k), 5'(k + 1), 1'b1, 32'h400 + 32'(4 * k),
                     32'hD000 + 32'(k));
            drive_rsp(32'hD000 + 32'(k));
            idle();
            idle();
        end
        wait_drain(20);

        $display("[TB] store blocked by MSHR, then write buffer ordering");
        push_exp(K_MISS, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b1, 32'h500, 32'd0, 5'd9, 1'b0, 32'd0);
        push_exp(K_STALL, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b0, 32'h300, 32'h11, 5'd0, 1'b0, 32'd0);
        push_exp(K_DONE, 1'b1, 32'h5A5A, 5'd9, 1'b1, 32'h500, 32'h5A5A);
        drive_rsp(32'h5A5A);
        wait_drain(10);
        mem_req_ready = 1'b0;
        push_exp(K_HIT, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b0, 32'h300, 32'h11, 5'd0, 1'b0, 32'd0);
        check_output("wb_hold_valid", {31'd0, mem_req_valid}, 32'd1);
        check_output("wb_hold_addr", mem_req_addr, 32'h300);
        push_exp(K_MISS, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b1, 32'h600, 32'd0, 5'd3, 1'b0, 32'd0);
        check_output("wb_hold_we", {31'd0, mem_req_we}, 32'd1);
        check_output("wb_hold_wdata", mem_req_wdata, 32'h11);
        idle();
        check_output("wb_block_rd_we", {31'd0, mem_req_we}, 32'd1);
        check_output("wb_block_rd_addr", mem_req_addr, 32'h300);
        mem_req_ready = 1'b1;
        idle();
        check_output("rd_after_wb_valid", {31'd0, mem_req_valid}, 32'd1);
        check_output("rd_after_wb_we", {31'd0, mem_req_we}, 32'd0);
        check_output("rd_after_wb_addr", mem_req_addr, 32'h600);
        idle();
        push_exp(K_DONE, 1'b1, 32'h6060, 5'd3, 1'b1, 32'h600, 32'h6060);
        drive_rsp(32'h6060);
        wait_drain(10);

        $display("[TB] request colliding with a completion");
        push_exp(K_MISS, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b1, 32'h700, 32'd0, 5'd5, 1'b0, 32'd0);
        idle();
        push_exp(K_DONE, 1'b1, 32'h7070, 5'd5, 1'b1, 32'h700, 32'h7070);
        drive_rsp(32'h7070);
        apply_stimulus(1'b1, 32'h710, 32'd0, 5'd0, 1'b1, 32'h77);
        check_output("collide_done", {31'd0, load_done_stall}, 32'd1);
        check_output("collide_no_hit", {31'd0, hit_ack}, 32'd0);
        push_exp(K_HIT, 1'b1, 32'h77, 5'd0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b1, 32'h710, 32'd0, 5'd0, 1'b1, 32'h77);
        check_output("reissue_hit", {31'd0, hit_ack}, 32'd1);
        wait_drain(10);

        $display("[TB] reset while a read is outstanding");
        push_exp(K_MISS, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b1, 32'h800, 32'd0, 5'd10, 1'b0, 32'd0);
        push_exp(K_MISS, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b1, 32'h804, 32'd0, 5'd11, 1'b0, 32'd0);
        wait_drain(5);
`ifdef MSHR_PERF_EN
        check_output("perf_hit", perf_hit, 32'(exp_hit_cnt));
        check_output("perf_miss", perf_miss, 32'(exp_miss_cnt));
        check_output("perf_stall", perf_stall, 32'(exp_stall_cnt));
`else
        check_output("perf_hit_off", perf_hit, 32'd0);
        check_output("perf_miss_off", perf_miss, 32'd0);
`endif
        rst = 1'b1;
        #2;
        check_output("rst2_miss_store", {31'd0, miss_store}, 32'd0);
        check_output("rst2_mem_req", {31'd0, mem_req_valid}, 32'd0);
        check_output("rst2_data", mmio_data_read, 32'd0);
        check_output("rst2_regd", {27'd0, regD_done}, 32'd0);
        check_output("rst2_perf_miss", perf_miss, 32'd0);
        check_output("rst2_perf_stall", perf_stall, 32'd0);
        idle();
        rst = 1'b0;
        drive_rsp(32'hBAD0);
        repeat (4) idle();
        check_output("post_rst_no_read", {31'd0, mem_req_valid}, 32'd0);
        check_output("post_rst_no_done", {31'd0, load_done_stall}, 32'd0);
        wait_drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
